md_sched: RTL and testbench

// - In-order request queue and dispatcher in front of the shared multiply/divide unit.
// - Accepts MUL/DIV ops from issue, buffers up to DEPTH entries and dispatches the oldest entry when the unit is ready.
// - Tracks the single in-flight op until its writeback; flushes everything on trap.

---
 rtl/md_sched.sv | 152 +++++++++++++++
 tb/tb_md_sched.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/md_sched.sv
// In-order request queue and single-outstanding dispatcher in front of the
// shared multiply/divide unit; trap or reset drops all buffered and in-flight state.
module md_sched #(
    parameter int DEPTH              = 4,
    parameter int PHY_REG_ADDR_WIDTH = 6,
    parameter int ROB_INDEX_WIDTH    = 6,
    parameter int XLEN               = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          trap,

    input  logic                          issue_md_req_valid_i,
    output logic                          issue_md_req_ready_o,
    input  logic [PHY_REG_ADDR_WIDTH-1:0] issue_md_prd_addr_i,
    input  logic [ROB_INDEX_WIDTH-1:0]    issue_md_rob_index_i,
    input  logic [XLEN-1:0]               issue_md_oprd1_i,
    input  logic [XLEN-1:0]               issue_md_oprd2_i,
    input  logic [2:0]                    issue_md_func_sel_i,
    input  logic                          issue_md_muldiv_i,

    output logic                          sched_md_req_valid_o,
    input  logic                          md_sched_req_ready_i,
    output logic [PHY_REG_ADDR_WIDTH-1:0] sched_md_prd_addr_o,
    output logic [ROB_INDEX_WIDTH-1:0]    sched_md_rob_index_o,
    output logic [XLEN-1:0]               sched_md_oprd1_o,
    output logic [XLEN-1:0]               sched_md_oprd2_o,
    output logic [2:0]                    sched_md_func_sel_o,
    output logic                          sched_md_muldiv_o,

    input  logic                          md_wrb_resp_valid_i,

    output logic [$clog2(DEPTH):0]        sched_count_o,
    output logic                          sched_idle_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int EW    = PHY_REG_ADDR_WIDTH + ROB_INDEX_WIDTH + 2 * XLEN + 3 + 1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    logic [EW-1:0]    entry_q [DEPTH];
    logic [EW-1:0]    entry_d [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [0:0]       state_q, state_d;

    logic             push;
    logic             pop;
    logic             inflight;
    logic [EW-1:0]    in_entry;
    logic [EW-1:0]    head_entry;

    assign inflight = (state_q == ST_BUSY);

    // Ready deliberately ignores a same-cycle pop so a full queue never passes through.
    assign issue_md_req_ready_o = (count_q < CNT_W'(DEPTH)) && !trap && !rst;
    assign sched_md_req_valid_o = (count_q != '0) && !inflight && !trap;

    assign push = issue_md_req_valid_i && issue_md_req_ready_o;
    assign pop  = sched_md_req_valid_o && md_sched_req_ready_i;

    assign in_entry = {issue_md_prd_addr_i,
                       issue_md_rob_index_i,
                       issue_md_oprd1_i,
                       issue_md_oprd2_i,
                       issue_md_func_sel_i,
                       issue_md_muldiv_i};

    // Only the slot under the tail pointer changes; the head slot is never
    // rewritten while occupied, which keeps the offered fields stable.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            assign entry_d[gi] = (push && (tail_q == PTR_W'(gi))) ? in_entry : entry_q[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= entry_d[i];
            end
        end
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        state_d = state_q;

        if (push) begin
            tail_d = tail_q + 1'b1;
        end
        if (pop) begin
            head_d = head_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        case (state_q)
            ST_IDLE: if (pop)                 state_d = ST_BUSY;
            ST_BUSY: if (md_wrb_resp_valid_i) state_d = ST_IDLE;
            default:                          state_d = ST_IDLE;
        endcase

        // Trap discards everything, including any enqueue or dispatch this cycle.
        if (trap) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            state_q <= ST_IDLE;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            state_q <= state_d;
        end
    end

    assign head_entry = entry_q[head_q];

    assign {sched_md_prd_addr_o,
            sched_md_rob_index_o,
            sched_md_oprd1_o,
            sched_md_oprd2_o,
            sched_md_func_sel_o,
            sched_md_muldiv_o} = head_entry;

    assign sched_count_o = count_q;
    assign sched_idle_o  = (count_q == '0) && !inflight;

endmodule

// File: tb/tb_md_sched.sv
// Directed bench for md_sched: a vector table for the per-cycle queue/FSM
// behaviour plus hand sequences for wrap-around, long latency, field fidelity and reset.
module tb_md_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        trap;
    logic        v_i;
    logic        rdy_o;
    logic [5:0]  prd_i;
    logic [5:0]  rob_i;
    logic [63:0] op1_i;
    logic [63:0] op2_i;
    logic [2:0]  fsel_i;
    logic        muldiv_i;
    logic        sv_o;
    logic        md_rdy;
    logic [5:0]  prd_o;
    logic [5:0]  rob_o;
    logic [63:0] op1_o;
    logic [63:0] op2_o;
    logic [2:0]  fsel_o;
    logic        muldiv_o;
    logic        resp;
    logic [2:0]  cnt_o;
    logic        idle_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    md_sched dut (
        .clk                  (clk),
        .rst                  (rst),
        .trap                 (trap),
        .issue_md_req_valid_i (v_i),
        .issue_md_req_ready_o (rdy_o),
        .issue_md_prd_addr_i  (prd_i),
        .issue_md_rob_index_i (rob_i),
        .issue_md_oprd1_i     (op1_i),
        .issue_md_oprd2_i     (op2_i),
        .issue_md_func_sel_i  (fsel_i),
        .issue_md_muldiv_i    (muldiv_i),
        .sched_md_req_valid_o (sv_o),
        .md_sched_req_ready_i (md_rdy),
        .sched_md_prd_addr_o  (prd_o),
        .sched_md_rob_index_o (rob_o),
        .sched_md_oprd1_o     (op1_o),
        .sched_md_oprd2_o     (op2_o),
        .sched_md_func_sel_o  (fsel_o),
        .sched_md_muldiv_o    (muldiv_o),
        .md_wrb_resp_valid_i  (resp),
        .sched_count_o        (cnt_o),
        .sched_idle_o         (idle_o)
    );

    typedef struct {
        int v;
        int rob;
        int mdr;
        int rsp;
        int trp;
        int cnt;
        int sv;
        int rdy;
        int idl;
        int ckr;
        int hrob;
    } vec_t;

    localparam int NV = 21;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        v_i    = 1'b0;
        md_rdy = 1'b0;
        resp   = 1'b0;
        trap   = 1'b0;
    endtask

    task automatic set_op(input int rob);
        v_i      = 1'b1;
        rob_i    = 6'(rob);
        prd_i    = 6'(rob + 7);
        op1_i    = 64'(rob) * 64'h1111;
        op2_i    = 64'(rob) + 64'h100;
        fsel_i   = 3'(rob);
        muldiv_i = rob[0];
    endtask

    // One clock: inputs already applied at the falling edge; clear them just after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1 idle_inputs();
        @(negedge clk);
    endtask

    initial begin
        int pre_cnt;
        int exp_rob;
        int nxt_rob;

        //              v rob mdr rsp trp | cnt sv rdy idl ckr hrob
        vecs[0]  = '{1,  5, 0, 0, 0,   1, 1, 1, 0, 1,  5};
        vecs[1]  = '{0,  0, 1, 0, 0,   0, 0, 1, 0, 0,  0};
        vecs[2]  = '{0,  0, 0, 0, 0,   0, 0, 1, 0, 0,  0};
        vecs[3]  = '{0,  0, 0, 1, 0,   0, 0, 1, 1, 0,  0};
        vecs[4]  = '{0,  0, 0, 1, 0,   0, 0, 1, 1, 0,  0};
        vecs[5]  = '{1,  0, 0, 0, 0,   1, 1, 1, 0, 1,  0};
        vecs[6]  = '{1,  1, 0, 0, 0,   2, 1, 1, 0, 1,  0};
        vecs[7]  = '{1,  2, 0, 0, 0,   3, 1, 1, 0, 1,  0};
        vecs[8]  = '{1,  3, 0, 0, 0,   4, 1, 0, 0, 1,  0};
        vecs[9]  = '{1,  9, 0, 0, 0,   4, 1, 0, 0, 1,  0};
        vecs[10] = '{1,  9, 1, 0, 0,   3, 0, 1, 0, 1,  1};
        vecs[11] = '{0,  0, 0, 1, 0,   3, 1, 1, 0, 1,  1};
        vecs[12] = '{0,  0, 1, 0, 0,   2, 0, 1, 0, 1,  2};
        vecs[13] = '{0,  0, 0, 1, 0,   2, 1, 1, 0, 1,  2};
        vecs[14] = '{1, 10, 1, 0, 0,   2, 0, 1, 0, 1,  3};
        vecs[15] = '{1, 11, 0, 0, 0,   3, 0, 1, 0, 1,  3};
        vecs[16] = '{1, 12, 1, 0, 1,   0, 0, 1, 1, 0,  0};
        vecs[17] = '{0,  0, 0, 1, 0,   0, 0, 1, 1, 0,  0};
        vecs[18] = '{1, 13, 0, 0, 0,   1, 1, 1, 0, 1, 13};
        vecs[19] = '{0,  0, 1, 0, 0,   0, 0, 1, 0, 0,  0};
        vecs[20] = '{0,  0, 0, 1, 0,   0, 0, 1, 1, 0,  0};

        idle_inputs();
        rst = 1'b1;
        set_op(0);
        v_i = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("rst_ready", rdy_o, 0);
        chk("rst_valid", sv_o, 0);
        chk("rst_count", cnt_o, 0);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", rdy_o, 1);
        chk("post_rst_idle", idle_o, 1);

        for (int i = 0; i < NV; i++) begin
            pre_cnt = int'(cnt_o);
            if (vecs[i].v != 0) set_op(vecs[i].rob);
            md_rdy = vecs[i].mdr[0];
            resp   = vecs[i].rsp[0];
            trap   = vecs[i].trp[0];
            #1;
            if (vecs[i].v != 0 && pre_cnt == 0) chk($sformatf("v%0d_no_bypass", i), sv_o, 0);
            if (vecs[i].trp != 0) begin
                chk($sformatf("v%0d_trap_ready", i), rdy_o, 0);
                chk($sformatf("v%0d_trap_valid", i), sv_o, 0);
            end
            tick();
            chk($sformatf("v%0d_count", i), cnt_o, 64'(vecs[i].cnt));
            chk($sformatf("v%0d_valid", i), sv_o, 64'(vecs[i].sv));
            chk($sformatf("v%0d_ready", i), rdy_o, 64'(vecs[i].rdy));
            chk($sformatf("v%0d_idle", i), idle_o, 64'(vecs[i].idl));
            if (vecs[i].ckr != 0) begin
                chk($sformatf("v%0d_rob", i), rob_o, 64'(vecs[i].hrob));
                chk($sformatf("v%0d_prd", i), prd_o, 64'((vecs[i].hrob + 7) % 64));
            end
        end

        // Steady enq+deq at count 2 across the pointer wrap.
        set_op(20); tick();
        set_op(21); tick();
        exp_rob = 20;
        nxt_rob = 22;
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("wrap%0d_valid", k), sv_o, 1);
            chk($sformatf("wrap%0d_rob", k), rob_o, 64'(exp_rob));
            set_op(nxt_rob);
            md_rdy = 1'b1;
            tick();
            chk($sformatf("wrap%0d_count", k), cnt_o, 2);
            resp = 1'b1;
            tick();
            chk($sformatf("wrap%0d_count_rsp", k), cnt_o, 2);
            exp_rob++;
            nxt_rob++;
        end
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("drain%0d_rob", k), rob_o, 64'(exp_rob));
            md_rdy = 1'b1;
            tick();
            resp = 1'b1;
            tick();
            exp_rob++;
        end
        chk("drain_idle", idle_o, 1);

        // DIV with bit-exact fields, then a long-latency writeback with two ops queued.
        v_i = 1'b1; rob_i = 6'd33; prd_i = 6'd45; fsel_i = 3'b101; muldiv_i = 1'b1;
        op1_i = 64'hFFFF_FFFF_FFFF_FFFF; op2_i = 64'h1;
        tick();
        v_i = 1'b1; rob_i = 6'd34; prd_i = 6'd46; fsel_i = 3'b010; muldiv_i = 1'b0;
        op1_i = 64'h1234; op2_i = 64'h5678;
        tick();
        set_op(35);
        tick();
        chk("div_valid", sv_o, 1);
        chk("div_rob", rob_o, 33);
        chk("div_prd", prd_o, 45);
        chk("div_op1", op1_o, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("div_op2", op2_o, 64'h1);
        chk("div_fsel", fsel_o, 3'b101);
        chk("div_muldiv", muldiv_o, 1);
        md_rdy = 1'b1;
        tick();
        for (int k = 0; k < 20; k++) begin
            md_rdy = 1'b1;
            #1;
            chk($sformatf("hold%0d_valid", k), sv_o, 0);
            tick();
        end
        chk("hold_count", cnt_o, 2);
        resp = 1'b1;
        tick();
        chk("mul_valid", sv_o, 1);
        chk("mul_rob", rob_o, 34);
        chk("mul_prd", prd_o, 46);
        chk("mul_op1", op1_o, 64'h1234);
        chk("mul_op2", op2_o, 64'h5678);
        chk("mul_fsel", fsel_o, 3'b010);
        chk("mul_muldiv", muldiv_o, 0);

        // Reset in the middle of operation: one in flight, two queued.
        md_rdy = 1'b1;
        tick();
        set_op(36);
        tick();
        chk("mid_count", cnt_o, 2);
        chk("mid_idle", idle_o, 0);
        rst = 1'b1;
        #1;
        chk("mid_rst_ready", rdy_o, 0);
        tick();
        rst = 1'b0;
        #1;
        chk("mid_rst_count", cnt_o, 0);
        chk("mid_rst_idle", idle_o, 1);
        chk("mid_rst_valid", sv_o, 0);
        chk("mid_rst_ready_after", rdy_o, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
